sodor5_lockstep_checker: RTL and testbench

- Self-checking lockstep harness for the Sodor 5-stage integer datapath, restricted to register-register and register-immediate ALU instructions.
- Takes one 32-bit RV32I instruction per cycle and executes it through a fully bypassed 5-stage pipeline (F/D/X/M/W) with its own register file.
- With checking compiled in, a single-cycle architectural golden model runs in parallel and every pipeline writeback is compared against it.
- Sits between the instruction stimulus and the trace/scoreboard logic.

---
 rtl/sodor5_lockstep_checker.sv | 201 ++++++++++++++++++++
 tb/tb_sodor5_lockstep_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sodor5_lockstep_checker.sv
// Sodor-style 5-stage ALU pipeline (F/D/X/M/W) with full bypass and an optional golden model.
// Define SODOR5_LOCKSTEP_CHECK_EN to build the single-cycle reference and writeback compare.
module sodor5_lockstep_checker #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     instr,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     retire_count,
  output logic            mismatch,
  output logic [31:0]     mismatch_count
);

  typedef struct packed {
    logic            wr;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic            alt;
    logic [2:0]      f3;
  } dec_t;

  // Unsupported encodings and rd=0 writes collapse to wr=0 (bubble).
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d.rd      = i[11:7];
    d.rs1     = i[19:15];
    d.rs2     = i[24:20];
    d.f3      = i[14:12];
    d.imm     = {{(XLEN-12){i[31]}}, i[31:20]};
    d.use_imm = 1'b0;
    d.alt     = 1'b0;
    d.wr      = 1'b0;
    if (i[6:0] == 7'b0110011) begin
      d.alt = i[30];
      d.wr  = (i[31:25] == 7'b0000000) ||
              ((i[31:25] == 7'b0100000) && ((d.f3 == 3'b000) || (d.f3 == 3'b101)));
    end else if (i[6:0] == 7'b0010011) begin
      d.use_imm = 1'b1;
      d.alt     = (d.f3 == 3'b101) && i[30];
      d.wr      = 1'b1;
    end
    d.wr = d.wr && (d.rd != 5'd0);
    return d;
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic alt, input logic [2:0] f3,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << sh;
      3'b010:  alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  alu = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? XLEN'($signed(a) >>> sh) : (a >> sh);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  logic [XLEN-1:0] pipe_rf [0:NREGS-1];

  logic            fd_valid_q;
  logic [31:0]     fd_instr_q;
  logic            dx_wr_q, xm_wr_q, mw_wr_q;
  logic [4:0]      dx_rd_q, xm_rd_q, mw_rd_q;
  logic            dx_alt_q;
  logic [2:0]      dx_f3_q;
  logic [XLEN-1:0] dx_a_q, dx_b_q, xm_data_q, mw_data_q;

  dec_t            d_dec;
  logic [XLEN-1:0] d_rs1, d_rs2, x_result;

  assign d_dec    = decode(fd_instr_q);
  assign x_result = alu(dx_alt_q, dx_f3_q, dx_a_q, dx_b_q);

  // Youngest producer wins: X > M > W > register file.
  always_comb begin
    d_rs1 = '0;
    if (d_dec.rs1 == 5'd0)                        d_rs1 = '0;
    else if (dx_wr_q && (dx_rd_q == d_dec.rs1))   d_rs1 = x_result;
    else if (xm_wr_q && (xm_rd_q == d_dec.rs1))   d_rs1 = xm_data_q;
    else if (mw_wr_q && (mw_rd_q == d_dec.rs1))   d_rs1 = mw_data_q;
    else                                          d_rs1 = pipe_rf[d_dec.rs1];
    d_rs2 = '0;
    if (d_dec.rs2 == 5'd0)                        d_rs2 = '0;
    else if (dx_wr_q && (dx_rd_q == d_dec.rs2))   d_rs2 = x_result;
    else if (xm_wr_q && (xm_rd_q == d_dec.rs2))   d_rs2 = xm_data_q;
    else if (mw_wr_q && (mw_rd_q == d_dec.rs2))   d_rs2 = mw_data_q;
    else                                          d_rs2 = pipe_rf[d_dec.rs2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fd_valid_q   <= 1'b0;
      fd_instr_q   <= 32'h0000_0013;
      dx_wr_q      <= 1'b0;
      dx_rd_q      <= '0;
      dx_alt_q     <= 1'b0;
      dx_f3_q      <= '0;
      dx_a_q       <= '0;
      dx_b_q       <= '0;
      xm_wr_q      <= 1'b0;
      xm_rd_q      <= '0;
      xm_data_q    <= '0;
      mw_wr_q      <= 1'b0;
      mw_rd_q      <= '0;
      mw_data_q    <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      retire_count <= '0;
    end else begin
      fd_valid_q   <= 1'b1;
      fd_instr_q   <= instr;
      dx_wr_q      <= fd_valid_q && d_dec.wr;
      dx_rd_q      <= d_dec.rd;
      dx_alt_q     <= d_dec.alt;
      dx_f3_q      <= d_dec.f3;
      dx_a_q       <= d_rs1;
      dx_b_q       <= d_dec.use_imm ? d_dec.imm : d_rs2;
      xm_wr_q      <= dx_wr_q;
      xm_rd_q      <= dx_rd_q;
      xm_data_q    <= x_result;
      mw_wr_q      <= xm_wr_q;
      mw_rd_q      <= xm_rd_q;
      mw_data_q    <= xm_data_q;
      wb_valid     <= mw_wr_q;
      wb_rd        <= mw_wr_q ? mw_rd_q : 5'd0;
      wb_data      <= mw_wr_q ? mw_data_q : '0;
      retire_count <= retire_count + 32'(wb_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (mw_wr_q) pipe_rf[mw_rd_q] <= mw_data_q;
  end

`ifdef SODOR5_LOCKSTEP_CHECK_EN
  logic [XLEN-1:0] arch_rf [0:NREGS-1];
  dec_t            g_dec;
  logic [XLEN-1:0] g_a, g_b, g_res;
  logic [3:0]      dl_wr_q;
  logic [4:0]      dl_rd_q   [4];
  logic [XLEN-1:0] dl_data_q [4];
  logic            mismatch_q, cmp_fail;
  logic [31:0]     mismatch_count_q;

  always_comb begin
    g_dec = decode(instr);
    g_a   = (g_dec.rs1 == 5'd0) ? '0 : arch_rf[g_dec.rs1];
    g_b   = g_dec.use_imm ? g_dec.imm : ((g_dec.rs2 == 5'd0) ? '0 : arch_rf[g_dec.rs2]);
    g_res = alu(g_dec.alt, g_dec.f3, g_a, g_b);
  end

  // Entry 3 holds the expectation for the instruction currently in W.
  assign cmp_fail = mw_wr_q && (!dl_wr_q[3] || (dl_rd_q[3] != mw_rd_q) ||
                                (dl_data_q[3] != mw_data_q));

  // arch_rf is deliberately not reset; reset only blocks its update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_wr_q          <= '0;
      for (int n = 0; n < 4; n++) begin
        dl_rd_q[n]   <= '0;
        dl_data_q[n] <= '0;
      end
      mismatch_q       <= 1'b0;
      mismatch_count_q <= '0;
    end else begin
      if (g_dec.wr) arch_rf[g_dec.rd] <= g_res;
      dl_wr_q      <= {dl_wr_q[2:0], g_dec.wr};
      dl_rd_q[0]   <= g_dec.rd;
      dl_data_q[0] <= g_res;
      for (int n = 1; n < 4; n++) begin
        dl_rd_q[n]   <= dl_rd_q[n-1];
        dl_data_q[n] <= dl_data_q[n-1];
      end
      if (cmp_fail) begin
        mismatch_q       <= 1'b1;
        mismatch_count_q <= mismatch_count_q + 32'd1;
      end
    end
  end

  assign mismatch       = mismatch_q;
  assign mismatch_count = mismatch_count_q;
`else
  assign mismatch       = 1'b0;
  assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_sodor5_lockstep_checker.sv
// Directed bench for sodor5_lockstep_checker: latency, bypass, ALU ops, x0, reset, lockstep compare.
module tb_sodor5_lockstep_checker;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] retire_count;
  logic        mismatch;
  logic [31:0] mismatch_count;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          k0;
  logic [31:0] rd_log [$];
  logic [31:0] data_log [$];
  int          cyc_log [$];
  logic        chk_en;

  sodor5_lockstep_checker dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr          (instr),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .retire_count   (retire_count),
    .mismatch       (mismatch),
    .mismatch_count (mismatch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wb_valid) begin
      rd_log.push_back({27'd0, wb_rd});
      data_log.push_back(wb_data);
      cyc_log.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input int idx, input logic [31:0] rd, input logic [31:0] data);
    chk($sformatf("wb%0d_rd", idx), (idx < rd_log.size()) ? rd_log[idx] : 32'hxxxx_xxxx, rd);
    chk($sformatf("wb%0d_data", idx), (idx < data_log.size()) ? data_log[idx] : 32'hxxxx_xxxx,
        data);
  endtask

  task automatic issue(input logic [31:0] i);
    instr = i;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) issue(Nop);
  endtask

  task automatic clear_log();
    rd_log.delete();
    data_log.delete();
    cyc_log.delete();
  endtask

  task automatic set_reg(input int r, input logic [31:0] v);
    dut.pipe_rf[r] = v;
`ifdef SODOR5_LOCKSTEP_CHECK_EN
    dut.arch_rf[r] = v;
`endif
  endtask

  initial begin
`ifdef SODOR5_LOCKSTEP_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    reset_n = 1'b1;
    instr   = Nop;
    #2 reset_n = 1'b0;
    for (int r = 0; r < 32; r++) set_reg(r, 32'd0);
    set_reg(1, 32'd5);
    set_reg(2, 32'd3);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("rst_mm_count", mismatch_count, 32'd0);
    reset_n = 1'b1;
    drain(2);

    // Single add: latency and counters
    clear_log();
    issue(32'h0020_81B3);
    k0 = cyc;
    drain(7);
    chk("t1_count", rd_log.size(), 32'd1);
    chk_wb(0, 32'd3, 32'd8);
    chk("t1_latency", (cyc_log.size() > 0) ? cyc_log[0] - k0 : -1, 32'd4);
    chk("t1_retire", retire_count, 32'd1);
    chk("t1_mismatch", {31'd0, mismatch}, 32'd0);

    // Back-to-back dependency through X
    set_reg(3, 32'd0);
    clear_log();
    issue(32'h0020_81B3);
    issue(32'h4011_8233);
    drain(7);
    chk("t2_count", rd_log.size(), 32'd2);
    chk_wb(0, 32'd3, 32'd8);
    chk_wb(1, 32'd4, 32'd3);
    chk("t2_consecutive", (cyc_log.size() > 1) ? cyc_log[1] - cyc_log[0] : -1, 32'd1);

    // Bypass from M and W
    clear_log();
    issue(32'h0020_89B3);  // add x19,x1,x2
    issue(32'h0010_4913);  // xori x18,x0,1
    issue(32'h0139_8833);  // add x16,x19,x19
    issue(32'h0019_88B3);  // add x17,x19,x1
    drain(7);
    chk("t2b_count", rd_log.size(), 32'd4);
    chk_wb(0, 32'd19, 32'd8);
    chk_wb(1, 32'd18, 32'd1);
    chk_wb(2, 32'd16, 32'd16);
    chk_wb(3, 32'd17, 32'd13);

    // Shifts
    set_reg(1, 32'h8000_0000);
    set_reg(2, 32'd4);
    clear_log();
    issue(32'h4020_D2B3);  // sra x5,x1,x2
    issue(32'h0020_D4B3);  // srl x9,x1,x2
    drain(7);
    chk("t3_shift_count", rd_log.size(), 32'd2);
    chk_wb(0, 32'd5, 32'hF800_0000);
    chk_wb(1, 32'd9, 32'h0800_0000);

    // Compares and immediates
    set_reg(1, 32'hFFFF_FFFF);
    set_reg(2, 32'd1);
    clear_log();
    issue(32'h0020_A533);  // slt x10,x1,x2
    issue(32'h0020_B5B3);  // sltu x11,x1,x2
    issue(32'hFFF0_8613);  // addi x12,x1,-1
    issue(32'hFFF1_3693);  // sltiu x13,x2,-1
    drain(7);
    chk("t3_cmp_count", rd_log.size(), 32'd4);
    chk_wb(0, 32'd10, 32'd1);
    chk_wb(1, 32'd11, 32'd0);
    chk_wb(2, 32'd12, 32'hFFFF_FFFE);
    chk_wb(3, 32'd13, 32'd1);

    // x0 destination and x0 sources
    set_reg(6, 32'h55);
    clear_log();
    issue(32'h0020_8033);  // add x0,x1,x2
    issue(32'h0000_0333);  // add x6,x0,x0
    drain(7);
    chk("t4_count", rd_log.size(), 32'd1);
    chk_wb(0, 32'd6, 32'd0);
    chk("t4_x6", dut.pipe_rf[6], 32'd0);

    // Mid-stream reset drops in-flight writes
    set_reg(20, 32'h1234);
    clear_log();
    issue(32'h0070_0A13);
    issue(32'h0070_0A13);
    issue(32'h0070_0A13);
    reset_n = 1'b0;
    instr   = Nop;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drain(7);
    chk("t5_count", rd_log.size(), 32'd0);
    chk("t5_retire", retire_count, 32'd0);
    chk("t5_x20", dut.pipe_rf[20], 32'h1234);
    chk("t5_x1", dut.pipe_rf[1], 32'hFFFF_FFFF);
    chk("t5_mismatch", {31'd0, mismatch}, 32'd0);
`ifdef SODOR5_LOCKSTEP_CHECK_EN
    chk("t5_arch_x1", dut.arch_rf[1], 32'hFFFF_FFFF);
    dut.arch_rf[20] = 32'h1234;
`endif

    // Corrupted pipeline register file is caught by the golden model
    dut.pipe_rf[7] = 32'h99;
    clear_log();
    issue(32'h0003_8433);  // add x8,x7,x0
    drain(7);
    chk("t6_count", rd_log.size(), 32'd1);
    chk_wb(0, 32'd8, 32'h99);
    chk("t6_mismatch", {31'd0, mismatch}, {31'd0, chk_en});
    chk("t6_mm_count", mismatch_count, {31'd0, chk_en});
    issue(32'h0020_81B3);  // add x3,x1,x2 (consistent in both)
    drain(7);
    chk("t6_sticky", {31'd0, mismatch}, {31'd0, chk_en});
    chk("t6_mm_count2", mismatch_count, {31'd0, chk_en});
    chk("t6_retire", retire_count, 32'd2);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("t6_rst_mm_count", mismatch_count, 32'd0);
    reset_n = 1'b1;
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
